// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add done one 4-bit slice per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub_i port and A-B operation.

module fulladder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [4:0] c;

  // Four full adders chained through the carry.
  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < 4; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) |
                 (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o = c[4];

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  cy_q, cy_d;
  logic [N-1:0][3:0]     a_q, a_d;
  logic [N-1:0][3:0]     b_q, b_d;
  logic [N-1:0][3:0]     sum_q, sum_d;
  logic                  cout_q, cout_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;

  logic [3:0]            sl_s;
  logic                  sl_c;

  // The one shared slice, steered by the nibble index.
  fulladder4 u_slice (
    .a_i (a_q[idx_q]),
    .b_i (b_q[idx_q]),
    .c_i (cy_q),
    .s_o (sl_s),
    .c_o (sl_c)
  );

  // Next-state and next-output decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ready_d = ready_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_i) begin
          a_d     = a_i;
          b_d     = b_i;
          cy_d    = carry_i;
`ifdef SERIAL_ADDER_SUB_EN
          if (sub_i) begin
            b_d  = ~b_i;
            cy_d = 1'b1;
          end
`endif
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ready_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        ready_d      = 1'b0;
        sum_d[idx_q] = sl_s;
        cy_d         = sl_c;
        if (idx_q == LAST) begin
          cout_d  = sl_c;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset drops any partial result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign carry_o = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed + random checks on WIDTH 4, 8 and 32.
// Reference result is plain integer arithmetic on the operands.

module tb_nibble_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req4, req8, req32;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic        c4, c8, c32;
  logic        sb4, sb8, sb32;
  logic        rdy4, rdy8, rdy32;
  logic        vld4, vld8, vld32;
  logic [3:0]  s4;
  logic [7:0]  s8;
  logic [31:0] s32;
  logic        co4, co8, co32;

  int checks = 0;
  int failures = 0;

  nibble_serial_adder #(.WIDTH(4)) u4 (
    .clk_i(clk), .rst_i(rst), .req_i(req4),
    .a_i(a4), .b_i(b4), .carry_i(c4),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i(sb4),
`endif
    .ready_o(rdy4), .valid_o(vld4),
    .sum_o(s4), .carry_o(co4)
  );

  nibble_serial_adder #(.WIDTH(8)) u8 (
    .clk_i(clk), .rst_i(rst), .req_i(req8),
    .a_i(a8), .b_i(b8), .carry_i(c8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i(sb8),
`endif
    .ready_o(rdy8), .valid_o(vld8),
    .sum_o(s8), .carry_o(co8)
  );

  nibble_serial_adder #(.WIDTH(32)) u32 (
    .clk_i(clk), .rst_i(rst), .req_i(req32),
    .a_i(a32), .b_i(b32), .carry_i(c32),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i(sb32),
`endif
    .ready_o(rdy32), .valid_o(vld32),
    .sum_o(s32), .carry_o(co32)
  );

  task automatic check(input string tag,
                       input logic [63:0] o,
                       input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] obs(input int w);
    case (w)
      4:       return 64'({co4, s4});
      8:       return 64'({co8, s8});
      default: return 64'({co32, s32});
    endcase
  endfunction

  function automatic logic obs_rdy(input int w);
    case (w)
      4:       return rdy4;
      8:       return rdy8;
      default: return rdy32;
    endcase
  endfunction

  function automatic logic obs_vld(input int w);
    case (w)
      4:       return vld4;
      8:       return vld8;
      default: return vld32;
    endcase
  endfunction

  // {carry, sum}: A+B+cin, or for subtract (A-B mod 2^w) with no-borrow flag.
  function automatic logic [63:0] model(input int w,
                                       input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic c,
                                       input logic s);
    longint unsigned m, av, bv;
    m  = 64'd1 << w;
    av = longint'(a) % m;
    bv = longint'(b) % m;
    if (s)
      return ((av + m - bv) % m) + ((av >= bv) ? m : 0);
    return av + bv + longint'(c);
  endfunction

  task automatic drive(input int w, input logic r,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s);
    case (w)
      4: begin
        req4 = r; a4 = a[3:0]; b4 = b[3:0]; c4 = c; sb4 = s;
      end
      8: begin
        req8 = r; a8 = a[7:0]; b8 = b[7:0]; c8 = c; sb8 = s;
      end
      default: begin
        req32 = r; a32 = a; b32 = b; c32 = c; sb32 = s;
      end
    endcase
  endtask

  // One full transaction; poke drives a stray request during RUN.
  task automatic op(input int w, input logic [31:0] a,
                    input logic [31:0] b, input logic c,
                    input logic s, input bit poke);
    int n, k, cnt;
    logic [63:0] exp;
    n = w / 4;
    k = 0;
    while (!obs_rdy(w) && k < 50) begin
      tick();
      k++;
    end
    check("rdy_wait", 64'(obs_rdy(w)), 64'd1);
    exp = model(w, a, b, c, s);
    drive(w, 1'b1, a, b, c, s);
    tick();
    drive(w, 1'b0, $urandom, $urandom, 1'b1, 1'b0);
    check("acc_busy", 64'(obs_rdy(w)), 64'd0);
    check("acc_clr", obs(w), 64'd0);
    cnt = 0;
    while (!obs_vld(w) && cnt < n + 5) begin
      if (poke && cnt == 1)
        drive(w, 1'b1, ~a, a, 1'b1, 1'b0);
      if (poke && cnt == 2)
        drive(w, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      tick();
      cnt++;
    end
    check("latency", 64'(cnt), 64'(n));
    check("result", obs(w), exp);
    check("done_rdy", 64'(obs_rdy(w)), 64'd0);
    tick();
    check("vld_1cyc", 64'(obs_vld(w)), 64'd0);
    check("rdy_back", 64'(obs_rdy(w)), 64'd1);
    check("hold", obs(w), exp);
  endtask

  logic [63:0] q_exp[$];
  logic [63:0] pe, cur;
  int          last_acc, vcnt, k;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(4, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(8, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(32, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_rdy8", 64'(rdy8), 64'd1);
    check("rst_vld8", 64'(vld8), 64'd0);
    check("rst_out8", obs(8), 64'd0);
    check("rst_rdy32", 64'(rdy32), 64'd1);
    check("rst_out32", obs(32), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rdy4", 64'(rdy4), 64'd1);
    check("post_vld32", 64'(vld32), 64'd0);
    check("post_out4", obs(4), 64'd0);

    op(8, 32'h0F, 32'h01, 1'b0, 1'b0, 1'b0);
    op(8, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b0);
    op(8, 32'h00, 32'h00, 1'b1, 1'b0, 1'b0);
    op(4, 32'hF, 32'hF, 1'b1, 1'b0, 1'b0);
    op(32, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0);
    op(32, 32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b1);

    // Reset mid-operation on the 32-bit instance.
    drive(32, 1'b1, 32'h12345678, 32'h11111111, 1'b0, 1'b0);
    tick();
    drive(32, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    check("mid_partial", 64'(obs(32) != 0), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rdy", 64'(rdy32), 64'd1);
    check("mid_out", obs(32), 64'd0);
    check("mid_vld", 64'(vld32), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (vld32) vcnt++;
      tick();
    end
    check("mid_novld", 64'(vcnt), 64'd0);

    // req held high: accepts every N+2 cycles with operands at that edge.
    last_acc = -1;
    for (int i = 0; i < 24; i++) begin
      drive(8, 1'b1, $urandom, $urandom, 1'($urandom), 1'b0);
      if (vld8) begin
        pe = q_exp.size() > 0 ? q_exp.pop_front() : 64'hDEAD;
        check("b2b_res", obs(8), pe);
      end
      if (rdy8) begin
        q_exp.push_back(model(8, 32'(a8), 32'(b8), c8, 1'b0));
        if (last_acc >= 0)
          check("b2b_gap", 64'(i - last_acc), 64'd4);
        last_acc = i;
      end
      tick();
    end
    drive(8, 1'b0, 0, 0, 1'b0, 1'b0);
    k = 0;
    while (q_exp.size() > 0 && k < 20) begin
      if (vld8) begin
        pe = q_exp.pop_front();
        check("b2b_drain", obs(8), pe);
      end
      tick();
      k++;
    end
    check("b2b_empty", 64'(q_exp.size()), 64'd0);

    for (int i = 0; i < 10; i++) begin
      op(8, $urandom, $urandom, 1'($urandom), 1'b0, 1'b0);
      op(32, $urandom, $urandom, 1'($urandom), 1'b0, 1'b0);
      op(4, $urandom, $urandom, 1'($urandom), 1'b0, 1'b0);
    end

`ifdef SERIAL_ADDER_SUB_EN
    op(8, 32'h05, 32'h07, 1'b0, 1'b1, 1'b0);
    op(8, 32'h07, 32'h05, 1'b0, 1'b1, 1'b0);
    op(8, 32'h33, 32'h33, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      op(32, $urandom, $urandom, 1'($urandom), 1'b1, 1'b0);
      op(4, $urandom, $urandom, 1'($urandom), 1'b1, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
